filtro_seq_ctrl: RTL and testbench
==================================

Name: filtro_seq_ctrl

Overview:
Sequencer for the 3-tap filter section built around the fk/fk_1/fk_2 sample mux and an external multiply-accumulate unit.
- Owns the sample delay line and drives the mux select, the coefficient select and the accumulator controls.
- Captures the MAC result once per input sample.
- Sits between the ADC-side sample strobe and the DAC-side output register.

Parameters:
W, 25, sample/result width (matches the 25-bit mux datapath)
MAC_LAT, 2, cycles from last acc_en to valid mac_result; legal range 1..7

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
sample_in  input  W  new input sample
sample_valid  input  1  one-cycle strobe, sample_in valid
ready  output  1  high when a sample can be accepted
fk  output  W  current sample register (mux input 00)
fk_1  output  W  one-sample delay (mux input 01)
fk_2  output  W  two-sample delay (mux input 10)
select  output  2  mux select; 2'b11 forces mux output to 0
coef_sel  output  2  coefficient ROM index, equal to select
acc_clr  output  1  accumulator loads the product instead of adding it
acc_en  output  1  accumulator update enable
mac_result  input  W  accumulator output
y  output  W  registered filter output
y_valid  output  1  one-cycle pulse, y updated
overrun  output  1  sticky: a sample arrived while busy
clr_ovr  input  1  clears overrun

Behaviour:
- Reset, synchronous and active-high, applies at the next clk edge and aborts any operation in progress:
  - state=IDLE; fk, fk_1, fk_2, y = 0
  - select=2'b11; acc_clr, acc_en, y_valid, overrun = 0; wait counter = 0
- All outputs are registered or decoded from state only; no input-to-output combinational path.
- States and per-state outputs:
  - IDLE: ready=1, select=11. On sample_valid: fk<=sample_in, go to MAC0.
  - MAC0: select=00, acc_clr=1, acc_en=1. Go to MAC1.
  - MAC1: select=01, acc_en=1. Go to MAC2.
  - MAC2: select=10, acc_en=1. Go to WAIT; load counter with MAC_LAT-1.
  - WAIT: select=11, acc_en=0. Decrement counter each cycle; at 0, go to CAPT. WAIT lasts exactly MAC_LAT cycles.
  - CAPT: select=11. Latch y<=mac_result. Shift delay line: fk_2<=fk_1, fk_1<=fk. Go to IDLE. y_valid=1 in the following cycle, together with the new y value.
- acc_clr and acc_en are asserted only in the states listed above; zero elsewhere.
- ready is high only in IDLE.
- Latency: sample_valid sampled at edge t ⇒ y_valid high in cycle t+5+MAC_LAT. Throughput is one sample per 5+MAC_LAT cycles.
- fk holds the newest sample from acceptance until the next acceptance. After CAPT, fk_1 equals fk until the next sample overwrites fk. This is intended: the next pass uses the new fk, the shifted fk_1 and fk_2.
- sample_valid while ready=0: sample dropped, overrun<=1, datapath unaffected.
- overrun behaviour: clr_ovr clears it. If clr_ovr and a drop occur in the same cycle, set wins (overrun=1).
- sample_valid and reset in the same cycle: reset wins, sample not captured.
- No arithmetic in this block: y is mac_result copied bit-exact, with no saturation or truncation.

Decomposition:
- Shared package filtro_pkg:
  - state encoding localparams IDLE, MAC0, MAC1, MAC2, WAIT, CAPT
  - SEL_FK=2'b00, SEL_FK1=2'b01, SEL_FK2=2'b10, SEL_ZERO=2'b11
  - default W=25
- One natural sub-module: filtro_delay_line (fk/fk_1/fk_2 registers with load and shift enables). The FSM stays in the top.

Test Plan:
- Reset check: assert reset 3 cycles, then release.
  - fk, fk_1, fk_2, y = 0; select=11; ready=1; y_valid=0; overrun=0.
- Single sample, MAC_LAT=2: sample_in=25'd100 with valid at t.
  - select sequence 00,01,10 in cycles t+1..t+3; acc_clr only at t+1; acc_en at t+1..t+3.
  - Mock MAC returns 25'h0ABCDE; y=25'h0ABCDE with y_valid at t+7.
  - fk_1=100, fk_2=0 afterwards.
- Three samples 1, 2, 3, each sent when ready=1.
  - After the third capture: fk=3, fk_1=3, fk_2=2.
  - Mux inputs during the third pass are 3, 2, 1 in select order.
- Overrun: valid again 2 cycles after acceptance.
  - overrun=1, fk unchanged, y_valid count unchanged.
  - clr_ovr for 1 cycle ⇒ overrun=0.
  - clr_ovr coinciding with a drop ⇒ overrun stays 1.
- Reset in MAC1: reset mid-pass.
  - Next cycle: IDLE, select=11, acc_en=0, no y_valid pulse, delay line zero.
- MAC_LAT=1 and MAC_LAT=7 builds: y_valid at t+6 and t+12 respectively; ready returns the same cycle y_valid rises.

Source files
------------

// File: rtl/filtro_pkg.sv
// Shared types and constants for the 3-tap filter sequencer.
package filtro_pkg;

    localparam int unsigned W_DEF = 25;
    localparam int unsigned CNT_W = 3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MAC0 = 3'd1,
        MAC1 = 3'd2,
        MAC2 = 3'd3,
        WAIT = 3'd4,
        CAPT = 3'd5
    } state_t;

    localparam logic [1:0] SEL_FK   = 2'b00;
    localparam logic [1:0] SEL_FK1  = 2'b01;
    localparam logic [1:0] SEL_FK2  = 2'b10;
    localparam logic [1:0] SEL_ZERO = 2'b11;

endpackage

// File: rtl/filtro_delay_line.sv
// Sample delay line feeding the fk/fk_1/fk_2 mux inputs.
module filtro_delay_line
    import filtro_pkg::*;
#(
    parameter int unsigned W = W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic [W-1:0] fk,
    output logic [W-1:0] fk_1,
    output logic [W-1:0] fk_2
);

    // Load the newest sample into fk; shift the older taps after each capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            fk   <= '0;
            fk_1 <= '0;
            fk_2 <= '0;
        end else if (load) begin
            fk <= din;
        end else if (shift) begin
            fk_1 <= fk;
            fk_2 <= fk_1;
        end
    end

endmodule

// File: rtl/filtro_seq_ctrl.sv
// Sequencer for the 3-tap filter: drives mux/coef selects and MAC controls,
// captures the MAC result once per accepted sample.
module filtro_seq_ctrl
    import filtro_pkg::*;
#(
    parameter int unsigned W       = W_DEF,
    parameter int unsigned MAC_LAT = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] sample_in,
    input  logic         sample_valid,
    output logic         ready,
    output logic [W-1:0] fk,
    output logic [W-1:0] fk_1,
    output logic [W-1:0] fk_2,
    output logic [1:0]   select,
    output logic [1:0]   coef_sel,
    output logic         acc_clr,
    output logic         acc_en,
    input  logic [W-1:0] mac_result,
    output logic [W-1:0] y,
    output logic         y_valid,
    output logic         overrun,
    input  logic         clr_ovr
);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             load, shift, drop;
    logic [1:0]       select_next;
    logic             acc_clr_next, acc_en_next, ready_next;

    filtro_delay_line #(.W(W)) u_delay_line (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .shift (shift),
        .din   (sample_in),
        .fk    (fk),
        .fk_1  (fk_1),
        .fk_2  (fk_2)
    );

    // State, wait counter and per-state control outputs (decoded one cycle early).
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            select  <= SEL_ZERO;
            acc_clr <= 1'b0;
            acc_en  <= 1'b0;
            ready   <= 1'b1;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            select  <= select_next;
            acc_clr <= acc_clr_next;
            acc_en  <= acc_en_next;
            ready   <= ready_next;
        end
    end

    // Next-state logic plus output decode of the upcoming state.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        load         = 1'b0;
        shift        = 1'b0;
        select_next  = SEL_ZERO;
        acc_clr_next = 1'b0;
        acc_en_next  = 1'b0;
        ready_next   = 1'b0;

        case (state)
            IDLE: begin
                if (sample_valid) begin
                    load       = 1'b1;
                    state_next = MAC0;
                end
            end
            MAC0: state_next = MAC1;
            MAC1: state_next = MAC2;
            MAC2: begin
                state_next = WAIT;
                cnt_next   = CNT_W'(MAC_LAT - 1);
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_next = CAPT;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            CAPT: begin
                shift      = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        case (state_next)
            IDLE: ready_next = 1'b1;
            MAC0: begin
                select_next  = SEL_FK;
                acc_clr_next = 1'b1;
                acc_en_next  = 1'b1;
            end
            MAC1: begin
                select_next = SEL_FK1;
                acc_en_next = 1'b1;
            end
            MAC2: begin
                select_next = SEL_FK2;
                acc_en_next = 1'b1;
            end
            default: select_next = SEL_ZERO;
        endcase
    end

    assign coef_sel = select;
    assign drop     = sample_valid && (state != IDLE);

    // Result capture, y_valid pulse and sticky overrun (a drop beats a clear).
    always_ff @(posedge clk) begin
        if (reset) begin
            y       <= '0;
            y_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            y_valid <= (state == CAPT);
            if (state == CAPT) begin
                y <= mac_result;
            end
            if (drop) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_filtro_seq_ctrl.sv
// Directed bench for filtro_seq_ctrl (MAC_LAT = 2, plus 1 and 7 latency builds).
module tb_filtro_seq_ctrl;

    localparam int unsigned W = 25;

    logic         clk = 1'b0;
    logic         reset, sample_valid, clr_ovr;
    logic [W-1:0] sample_in, mac_result;

    logic         ready, y_valid, overrun, acc_clr, acc_en;
    logic [W-1:0] fk, fk_1, fk_2, y;
    logic [1:0]   select, coef_sel;

    logic         sv1, sv7;
    logic         ready1, y_valid1, overrun1, acc_clr1, acc_en1;
    logic [W-1:0] fk1, fk1_1, fk1_2, y1;
    logic [1:0]   select1, coef_sel1;
    logic         ready7, y_valid7, overrun7, acc_clr7, acc_en7;
    logic [W-1:0] fk7, fk7_1, fk7_2, y7;
    logic [1:0]   select7, coef_sel7;

    int total = 0;
    int bad   = 0;
    int yv_cnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (y_valid === 1'b1) yv_cnt++;

    filtro_seq_ctrl #(.W(W), .MAC_LAT(2)) dut (
        .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
        .ready(ready), .fk(fk), .fk_1(fk_1), .fk_2(fk_2), .select(select),
        .coef_sel(coef_sel), .acc_clr(acc_clr), .acc_en(acc_en),
        .mac_result(mac_result), .y(y), .y_valid(y_valid), .overrun(overrun),
        .clr_ovr(clr_ovr)
    );

    filtro_seq_ctrl #(.W(W), .MAC_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sv1),
        .ready(ready1), .fk(fk1), .fk_1(fk1_1), .fk_2(fk1_2), .select(select1),
        .coef_sel(coef_sel1), .acc_clr(acc_clr1), .acc_en(acc_en1),
        .mac_result(mac_result), .y(y1), .y_valid(y_valid1), .overrun(overrun1),
        .clr_ovr(clr_ovr)
    );

    filtro_seq_ctrl #(.W(W), .MAC_LAT(7)) dut7 (
        .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sv7),
        .ready(ready7), .fk(fk7), .fk_1(fk7_1), .fk_2(fk7_2), .select(select7),
        .coef_sel(coef_sel7), .acc_clr(acc_clr7), .acc_en(acc_en7),
        .mac_result(mac_result), .y(y7), .y_valid(y_valid7), .overrun(overrun7),
        .clr_ovr(clr_ovr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (ready !== 1'b1 && k < 30) begin
            tick();
            k++;
        end
        chk("wait_ready", 32'(ready), 32'd1);
    endtask

    // Accept one sample on the main instance; returns in cycle t+1.
    task automatic send(input logic [W-1:0] v);
        wait_ready();
        sample_in    = v;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    function automatic logic [W-1:0] mux(input logic [1:0] s, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic [W-1:0] c);
        case (s)
            2'b00:   return a;
            2'b01:   return b;
            2'b10:   return c;
            default: return '0;
        endcase
    endfunction

    initial begin
        int t1, t7;
        reset        = 1'b1;
        sample_valid = 1'b0;
        sv1          = 1'b0;
        sv7          = 1'b0;
        clr_ovr      = 1'b0;
        sample_in    = '0;
        mac_result   = 25'h0ABCDE;

        // Reset for 3 cycles
        tick(3);
        reset = 1'b0;
        chk("rst_fk", 32'(fk), 32'd0);
        chk("rst_fk1", 32'(fk_1), 32'd0);
        chk("rst_fk2", 32'(fk_2), 32'd0);
        chk("rst_y", 32'(y), 32'd0);
        chk("rst_select", 32'(select), 32'd3);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_y_valid", 32'(y_valid), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        tick();

        // Single sample, MAC_LAT=2
        send(25'd100);
        chk("s1_sel_t1", 32'(select), 32'd0);
        chk("s1_coef_t1", 32'(coef_sel), 32'd0);
        chk("s1_clr_t1", 32'(acc_clr), 32'd1);
        chk("s1_en_t1", 32'(acc_en), 32'd1);
        chk("s1_ready_t1", 32'(ready), 32'd0);
        tick();
        chk("s1_sel_t2", 32'(select), 32'd1);
        chk("s1_clr_t2", 32'(acc_clr), 32'd0);
        chk("s1_en_t2", 32'(acc_en), 32'd1);
        tick();
        chk("s1_sel_t3", 32'(select), 32'd2);
        chk("s1_clr_t3", 32'(acc_clr), 32'd0);
        chk("s1_en_t3", 32'(acc_en), 32'd1);
        tick();
        chk("s1_sel_t4", 32'(select), 32'd3);
        chk("s1_en_t4", 32'(acc_en), 32'd0);
        tick(2);
        chk("s1_yv_t6", 32'(y_valid), 32'd0);
        chk("s1_ready_t6", 32'(ready), 32'd0);
        tick();
        chk("s1_yv_t7", 32'(y_valid), 32'd1);
        chk("s1_y_t7", 32'(y), 32'h0ABCDE);
        chk("s1_ready_t7", 32'(ready), 32'd1);
        chk("s1_fk", 32'(fk), 32'd100);
        chk("s1_fk1", 32'(fk_1), 32'd100);
        chk("s1_fk2", 32'(fk_2), 32'd0);
        tick();
        chk("s1_yv_t8", 32'(y_valid), 32'd0);

        // Three samples 1, 2, 3 from a clean delay line
        reset = 1'b1;
        tick();
        reset = 1'b0;
        send(25'd1);
        send(25'd2);
        send(25'd3);
        chk("s3_mux0", 32'(mux(select, fk, fk_1, fk_2)), 32'd3);
        tick();
        chk("s3_mux1", 32'(mux(select, fk, fk_1, fk_2)), 32'd2);
        tick();
        chk("s3_mux2", 32'(mux(select, fk, fk_1, fk_2)), 32'd1);
        wait_ready();
        chk("s3_fk", 32'(fk), 32'd3);
        chk("s3_fk1", 32'(fk_1), 32'd3);
        chk("s3_fk2", 32'(fk_2), 32'd2);

        // Overrun: valid 2 cycles after acceptance
        send(25'd50);
        tick();
        sample_in    = 25'd999;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        chk("ovr_set", 32'(overrun), 32'd1);
        chk("ovr_fk", 32'(fk), 32'd50);
        wait_ready();
        tick();
        chk("ovr_yv_cnt", 32'(yv_cnt), 32'd5);
        chk("ovr_fk_after", 32'(fk), 32'd50);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        chk("ovr_clr", 32'(overrun), 32'd0);
        send(25'd60);
        tick();
        sample_in    = 25'd888;
        sample_valid = 1'b1;
        clr_ovr      = 1'b1;
        tick();
        sample_valid = 1'b0;
        clr_ovr      = 1'b0;
        chk("ovr_set_wins", 32'(overrun), 32'd1);
        wait_ready();
        tick();
        chk("ovr_yv_cnt2", 32'(yv_cnt), 32'd6);
        chk("ovr_fk2", 32'(fk), 32'd60);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        chk("ovr_clr2", 32'(overrun), 32'd0);

        // Reset in MAC1
        send(25'd70);
        tick();
        chk("rm_sel_mac1", 32'(select), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rm_ready", 32'(ready), 32'd1);
        chk("rm_select", 32'(select), 32'd3);
        chk("rm_acc_en", 32'(acc_en), 32'd0);
        chk("rm_y_valid", 32'(y_valid), 32'd0);
        chk("rm_fk", 32'(fk), 32'd0);
        chk("rm_fk1", 32'(fk_1), 32'd0);
        chk("rm_fk2", 32'(fk_2), 32'd0);
        tick(12);
        chk("rm_no_pulse", 32'(yv_cnt), 32'd6);
        chk("rm_idle", 32'(ready), 32'd1);

        // Reset and sample_valid in the same cycle
        reset        = 1'b1;
        sample_in    = 25'd77;
        sample_valid = 1'b1;
        tick();
        reset        = 1'b0;
        sample_valid = 1'b0;
        chk("rv_fk", 32'(fk), 32'd0);
        tick();
        chk("rv_select", 32'(select), 32'd3);
        chk("rv_ready", 32'(ready), 32'd1);

        // MAC_LAT=1 and MAC_LAT=7 latency
        mac_result = 25'h1F0F0F;
        sample_in  = 25'd5;
        sv1        = 1'b1;
        sv7        = 1'b1;
        tick();
        sv1 = 1'b0;
        sv7 = 1'b0;
        t1 = -1;
        t7 = -1;
        for (int k = 1; k <= 20; k++) begin
            if (y_valid1 === 1'b1 && t1 < 0) begin
                t1 = k;
                chk("l1_ready", 32'(ready1), 32'd1);
                chk("l1_y", 32'(y1), 32'h1F0F0F);
            end
            if (y_valid7 === 1'b1 && t7 < 0) begin
                t7 = k;
                chk("l7_ready", 32'(ready7), 32'd1);
                chk("l7_y", 32'(y7), 32'h1F0F0F);
            end
            if (k == 11) chk("l7_ready_before", 32'(ready7), 32'd0);
            tick();
        end
        chk("l1_latency", 32'(t1), 32'd6);
        chk("l7_latency", 32'(t7), 32'd12);
        chk("l1_overrun", 32'(overrun1), 32'd0);
        chk("l7_overrun", 32'(overrun7), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
